branch_predict_ctrl: RTL and testbench

- Dynamic branch predictor and redirect controller for the 5-stage RV32I pipeline.
- Holds a direct-mapped table of 2-bit saturating counters (BHT) indexed by PC.
- In ID, it predicts conditional branches and steers fetch to the branch target.
- In EX, it checks the resolved outcome from the branch comparator/PCSel logic against the carried prediction, issues the redirect and flushes on mispredict, and trains the table.

---
 rtl/branch_predict_ctrl.sv | 94 +++++++++
 tb/tb_branch_predict_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - 2-bit BHT branch predictor with EX redirect/flush; optional perf counters via BP_PERF_CNT_EN
module branch_predict_ctrl #(
    parameter int          XLEN     = 32,
    parameter int          IDX_BITS = 6,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            id_is_branch,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_target,
    output logic            id_pred_taken,
    output logic            id_redirect,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_taken,
    input  logic            ex_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]     perf_br_cnt,
    output logic [31:0]     perf_mis_cnt
`endif
);

    localparam int              DEPTH   = 1 << IDX_BITS;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [1:0]          ctr_q [DEPTH];
    logic [1:0]          ctr_d;
    logic [IDX_BITS-1:0] id_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic                ex_update;
    logic                mispredict;

    assign id_idx     = id_pc[IDX_BITS+1:2];
    assign ex_idx     = ex_pc[IDX_BITS+1:2];
    assign ex_update  = ex_valid & ex_is_branch;
    assign mispredict = ex_update & (ex_taken != ex_pred_taken);

    // Fetch target is muxed outside; only the redirect decision is made here.
    logic unused_inputs;
    assign unused_inputs = ^{id_target, id_pc[1:0], id_pc[XLEN-1:IDX_BITS+2]};

    assign id_pred_taken  = id_valid & id_is_branch & ctr_q[id_idx][1];
    assign id_redirect    = id_pred_taken & ~mispredict;
    assign redirect_valid = mispredict;
    assign redirect_pc    = mispredict ? (ex_taken ? ex_target : ex_pc + PC_STEP) : '0;
    assign flush_if_id    = mispredict;
    assign flush_id_ex    = mispredict;

    always_comb begin
        ctr_d = ctr_q[ex_idx];
        if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'b01;
        end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'b01;
        end
    end

    // ID reads the pre-update value on a same-index collision; no bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= INIT_CTR;
        end else if (ex_update) begin
            ctr_q[ex_idx] <= ctr_d;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_cnt_q;
    logic [31:0] perf_mis_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt_q  <= '0;
            perf_mis_cnt_q <= '0;
        end else begin
            if (ex_update)  perf_br_cnt_q  <= perf_br_cnt_q + 32'd1;
            if (mispredict) perf_mis_cnt_q <= perf_mis_cnt_q + 32'd1;
        end
    end

    assign perf_br_cnt  = perf_br_cnt_q;
    assign perf_mis_cnt = perf_mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - scoreboard bench for branch_predict_ctrl
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_is_branch;
    logic [31:0] id_pc, id_target;
    logic        id_pred_taken, id_redirect;
    logic        ex_valid, ex_is_branch;
    logic [31:0] ex_pc, ex_target;
    logic        ex_taken, ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_cnt, perf_mis_cnt;
`endif

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_is_branch(id_is_branch), .id_pc(id_pc), .id_target(id_target),
        .id_pred_taken(id_pred_taken), .id_redirect(id_redirect),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex)
`ifdef BP_PERF_CNT_EN
        , .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt)
`endif
    );

    typedef struct packed {
        logic        idp;
        logic        idr;
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          mdl [64];
    int unsigned n_br = 0;
    int unsigned n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 1;
    endtask

    // Drive one cycle of stimulus, push the expectation, compare on the falling edge.
    task automatic step(input string tag,
                        input logic iv, input logic ib, input logic [31:0] ipc,
                        input logic ev, input logic eb, input logic [31:0] epc,
                        input logic [31:0] etgt, input logic et, input logic ep);
        exp_t e, g;
        logic mis;
        id_valid = iv; id_is_branch = ib; id_pc = ipc; id_target = ipc + 32'h40;
        ex_valid = ev; ex_is_branch = eb; ex_pc = epc; ex_target = etgt;
        ex_taken = et; ex_pred_taken = ep;
        mis   = ev & eb & (et != ep);
        e.idp = iv & ib & (mdl[idx_of(ipc)] >= 2);
        e.idr = e.idp & ~mis;
        e.rv  = mis;
        e.rpc = mis ? (et ? etgt : epc + 32'd4) : 32'd0;
        e.fl  = mis;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        g = '{id_pred_taken, id_redirect, redirect_valid, redirect_pc, flush_if_id};
        if (g !== e) begin
            check_eq({tag, ".id_pred_taken"}, 64'(id_pred_taken), 64'(e.idp));
            check_eq({tag, ".id_redirect"}, 64'(id_redirect), 64'(e.idr));
            check_eq({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(e.rv));
            check_eq({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(e.rpc));
            check_eq({tag, ".flush_if_id"}, 64'(flush_if_id), 64'(e.fl));
        end else begin
            check_eq(tag, 64'(g), 64'(e));
        end
        check_eq({tag, ".flush_id_ex"}, 64'(flush_id_ex), 64'(e.fl));
        @(posedge clk);
        if (ev & eb) begin
            n_br++;
            if (mis) n_mis++;
            if (et) mdl[idx_of(epc)] = (mdl[idx_of(epc)] == 3) ? 3 : mdl[idx_of(epc)] + 1;
            else    mdl[idx_of(epc)] = (mdl[idx_of(epc)] == 0) ? 0 : mdl[idx_of(epc)] - 1;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic id_only(input string tag, input logic [31:0] pc);
        step(tag, 1, 1, pc, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic ex_only(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic t, input logic p);
        step(tag, 0, 0, 32'h0, 1, 1, pc, tgt, t, p);
    endtask

    initial begin
        logic [31:0] pcs [4];
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'hFFFF_FFFC;
        rst_n = 1'b0;
        id_valid = 0; id_is_branch = 0; id_pc = 0; id_target = 0;
        ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_target = 0; ex_taken = 0; ex_pred_taken = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        idle("reset_idle");
        id_only("id_init_0x100", 32'h100);
        ex_only("ex_mis_taken", 32'h100, 32'h80, 1, 0);
        id_only("id_after_train", 32'h100);
        for (int i = 0; i < 3; i++) ex_only("ex_taken_sat", 32'h100, 32'h80, 1, 1);
        step("mis_nt_concurrent_id", 1, 1, 32'h100, 1, 1, 32'h100, 32'h80, 0, 1);
        id_only("id_still_taken", 32'h100);
        id_only("id_alias_0x200", 32'h200);
        step("ex_valid0", 1, 1, 32'h104, 0, 1, 32'h104, 32'h300, 1, 0);
        step("ex_notbranch", 1, 1, 32'h104, 1, 0, 32'h104, 32'h300, 1, 0);
        id_only("id_no_update", 32'h104);

        // Asynchronous reset with ID inputs held: prediction must drop at once.
        id_valid = 1; id_is_branch = 1; id_pc = 32'h100; ex_valid = 0; ex_is_branch = 0;
        @(negedge clk);
        check_eq("pre_reset_pred", 64'(id_pred_taken), 64'(1));
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_pred", 64'(id_pred_taken), 64'(0));
        model_reset();
        n_br = 0; n_mis = 0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        step("same_cycle_0x200", 1, 1, 32'h200, 1, 1, 32'h200, 32'h240, 1, 0);
        id_only("next_cycle_0x200", 32'h200);
        id_only("alias_0x100", 32'h100);
        ex_only("wrap_pc4", 32'hFFFF_FFFC, 32'h10, 0, 1);
        step("b2b_1", 1, 1, 32'hFFFF_FFFC, 1, 1, 32'h200, 32'h240, 1, 1);
        step("b2b_2", 1, 1, 32'h200, 1, 1, 32'h200, 32'h240, 0, 1);

        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom), 1'($urandom), pcs[$urandom_range(0, 3)],
                 1'($urandom), 1'($urandom), pcs[$urandom_range(0, 3)],
                 $urandom, 1'($urandom), 1'($urandom));
        end
        idle("final_idle");

`ifdef BP_PERF_CNT_EN
        check_eq("perf_br_cnt", 64'(perf_br_cnt), 64'(n_br));
        check_eq("perf_mis_cnt", 64'(perf_mis_cnt), 64'(n_mis));
`endif
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
